// File: rtl/hazard_fwd_ctrl.sv
// Hazard/forwarding controller driving stall, flush and operand-select inputs of the ID/EX register.
// Define HAZARD_FWD_EN to enable operand forwarding; otherwise every dependency is resolved by stalling.
module hazard_fwd_ctrl #(
    parameter int FLUSH_CYCLES = 1,
    parameter int RF_BYPASS    = 1
) (
    input  logic       clk,
    input  logic       clr,
    input  logic       en,
    input  logic [4:0] id_rs,
    input  logic [4:0] id_rt,
    input  logic       id_use_rs,
    input  logic       id_use_rt,
    input  logic [4:0] id_rd,
    input  logic       id_wreg,
    input  logic       id_load,
    input  logic       ex_branch_taken,
    output logic [1:0] fwd_a,
    output logic [1:0] fwd_b,
    output logic       stall,
    output logic       flush,
    output logic [1:0] state_o
);

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        STALL = 2'd1,
        FLUSH = 2'd2
    } state_t;

    state_t     state, state_nxt;
    logic [1:0] cnt, cnt_nxt;

    logic [4:0] sh_ex_rd, sh_mem_rd, sh_wb_rd;
    logic       sh_ex_wreg, sh_mem_wreg, sh_wb_wreg;
    logic       sh_ex_load, sh_mem_load, sh_wb_load;

    // Total stall cycles the current ID instruction needs; 0 means it may issue now.
    logic [1:0] need;
    logic [1:0] fwd_a_raw, fwd_b_raw;

    function automatic logic match(input logic wreg, input logic [4:0] rd,
                                   input logic [4:0] r, input logic use_r);
        return wreg && (rd == r) && (r != 5'd0) && use_r;
    endfunction

    logic ex_a, ex_b, mem_a, mem_b, wb_a, wb_b;

    always_comb begin
        ex_a  = match(sh_ex_wreg,  sh_ex_rd,  id_rs, id_use_rs);
        ex_b  = match(sh_ex_wreg,  sh_ex_rd,  id_rt, id_use_rt);
        mem_a = match(sh_mem_wreg, sh_mem_rd, id_rs, id_use_rs);
        mem_b = match(sh_mem_wreg, sh_mem_rd, id_rt, id_use_rt);
        wb_a  = match(sh_wb_wreg,  sh_wb_rd,  id_rs, id_use_rs);
        wb_b  = match(sh_wb_wreg,  sh_wb_rd,  id_rt, id_use_rt);
    end

`ifdef HAZARD_FWD_EN
    logic unused_bits;
    assign unused_bits = &{1'b0, sh_mem_load, sh_wb_load, wb_a, wb_b, (RF_BYPASS != 0)};

    always_comb begin
        need      = ((ex_a || ex_b) && sh_ex_load) ? 2'd1 : 2'd0;
        fwd_a_raw = (ex_a && !sh_ex_load) ? 2'd1 : (mem_a ? 2'd2 : 2'd0);
        fwd_b_raw = (ex_b && !sh_ex_load) ? 2'd1 : (mem_b ? 2'd2 : 2'd0);
    end
`else
    logic unused_bits;
    assign unused_bits = &{1'b0, sh_ex_load, sh_mem_load, sh_wb_load};

    // Youngest producer dictates the longest wait; WB only matters without regfile write-through.
    always_comb begin
        need      = 2'd0;
        fwd_a_raw = 2'd0;
        fwd_b_raw = 2'd0;
        if (ex_a || ex_b)
            need = (RF_BYPASS != 0) ? 2'd2 : 2'd3;
        else if (mem_a || mem_b)
            need = (RF_BYPASS != 0) ? 2'd1 : 2'd2;
        else if ((wb_a || wb_b) && (RF_BYPASS == 0))
            need = 2'd1;
    end
`endif

    always_comb begin
        stall     = 1'b0;
        flush     = 1'b0;
        state_nxt = state;
        cnt_nxt   = cnt;
        if (ex_branch_taken) begin
            flush = 1'b1;
            if (FLUSH_CYCLES > 1) begin
                state_nxt = FLUSH;
                cnt_nxt   = 2'(FLUSH_CYCLES - 1);
            end else begin
                state_nxt = RUN;
                cnt_nxt   = 2'd0;
            end
        end else begin
            case (state)
                RUN: begin
                    if (need != 2'd0) begin
                        stall     = 1'b1;
                        state_nxt = STALL;
                        cnt_nxt   = need - 2'd1;
                    end
                end
                // The instruction issues during the final STALL cycle once cnt has run out.
                STALL: begin
                    if (cnt != 2'd0) begin
                        stall   = 1'b1;
                        cnt_nxt = cnt - 2'd1;
                    end else begin
                        state_nxt = RUN;
                    end
                end
                FLUSH: begin
                    flush = 1'b1;
                    if (cnt <= 2'd1) begin
                        state_nxt = RUN;
                        cnt_nxt   = 2'd0;
                    end else begin
                        cnt_nxt = cnt - 2'd1;
                    end
                end
                default: begin
                    state_nxt = RUN;
                    cnt_nxt   = 2'd0;
                end
            endcase
        end
    end

    always_comb begin
        fwd_a   = (stall || flush) ? 2'd0 : fwd_a_raw;
        fwd_b   = (stall || flush) ? 2'd0 : fwd_b_raw;
        state_o = state;
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            state       <= RUN;
            cnt         <= 2'd0;
            sh_ex_rd    <= 5'd0;
            sh_ex_wreg  <= 1'b0;
            sh_ex_load  <= 1'b0;
            sh_mem_rd   <= 5'd0;
            sh_mem_wreg <= 1'b0;
            sh_mem_load <= 1'b0;
            sh_wb_rd    <= 5'd0;
            sh_wb_wreg  <= 1'b0;
            sh_wb_load  <= 1'b0;
        end else if (en) begin
            state       <= state_nxt;
            cnt         <= cnt_nxt;
            sh_wb_rd    <= sh_mem_rd;
            sh_wb_wreg  <= sh_mem_wreg;
            sh_wb_load  <= sh_mem_load;
            sh_mem_rd   <= sh_ex_rd;
            sh_mem_wreg <= sh_ex_wreg;
            sh_mem_load <= sh_ex_load;
            if (stall || flush) begin
                sh_ex_rd   <= 5'd0;
                sh_ex_wreg <= 1'b0;
                sh_ex_load <= 1'b0;
            end else begin
                sh_ex_rd   <= id_rd;
                sh_ex_wreg <= id_wreg;
                sh_ex_load <= id_load;
            end
        end
    end

endmodule
